// File: rtl/var_mac_sched.sv
// var_mac_sched: serial 9-tap binary-pixel MAC with bias and valid/ready handshakes.
// One weight per cycle is accumulated into a 24-bit accumulator, then the bias is
// added and the 20-bit result is held in DONE until the consumer takes it.
// Optional macro VAR_MAC_SAT_EN: clamp the result to 20-bit signed range instead
// of wrapping to the low 20 bits.
module var_mac_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_we,
  input  logic [3:0]  w_addr,
  input  logic [19:0] w_data,
  output logic        w_err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_px,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_v,
  output logic        busy
);

  localparam int unsigned NPIX = 9;
  localparam int unsigned DW   = 20;
  localparam int unsigned AW   = 24;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_BIAS = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LAST_K   = 4'd8;
  localparam logic [3:0] BIAS_ADR = 4'd9;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [3:0]           k;
  logic [NPIX-1:0]      px;
  logic signed [AW-1:0] acc;
  logic signed [DW-1:0] wv [NPIX];
  logic signed [DW-1:0] bias;

  logic                 accept_c;
  logic                 wr_ok_c;
  logic                 wr_bad_c;
  logic signed [DW-1:0] wsel_c;
  logic                 xsel_c;
  logic signed [AW-1:0] acc_add_c;
  logic signed [AW-1:0] acc_bias_c;
  logic [DW-1:0]        res_c;

  // Handshake and write qualification; coefficients only change while idle
  always_comb begin
    accept_c = (state == S_IDLE) && in_valid;
    wr_ok_c  = w_we && (state == S_IDLE) && (w_addr <= BIAS_ADR);
    wr_bad_c = w_we && !wr_ok_c;
  end

  // Select weight and pixel for the current tap index
  always_comb begin
    wsel_c = '0;
    xsel_c = 1'b0;
    for (int i = 0; i < int'(NPIX); i++) begin
      if (k == 4'(i)) begin
        wsel_c = wv[i];
        xsel_c = px[i];
      end
    end
  end

  // Accumulator update terms (sign-extended 20 -> 24 bits)
  always_comb begin
    acc_add_c  = acc + (xsel_c ? {{(AW-DW){wsel_c[DW-1]}}, wsel_c} : '0);
    acc_bias_c = acc + {{(AW-DW){bias[DW-1]}}, bias};
  end

  // Output conversion from the 24-bit sum to the 20-bit result
  always_comb begin
`ifdef VAR_MAC_SAT_EN
    if (acc_bias_c > 24'sd524287)
      res_c = 20'h7FFFF;
    else if (acc_bias_c < -24'sd524288)
      res_c = 20'h80000;
    else
      res_c = acc_bias_c[DW-1:0];
`else
    res_c = acc_bias_c[DW-1:0];
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c)      state_nxt = S_ACC;
      S_ACC:   if (k == LAST_K)   state_nxt = S_BIAS;
      S_BIAS:                     state_nxt = S_DONE;
      S_DONE:  if (out_ready)     state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Registered status outputs track the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      w_err     <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      out_valid <= (state_nxt == S_DONE);
      w_err     <= wr_bad_c;
    end
  end

  // Coefficient register file
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NPIX); i++) wv[i] <= '0;
      bias <= '0;
    end else if (wr_ok_c) begin
      for (int i = 0; i < int'(NPIX); i++) begin
        if (w_addr == 4'(i)) wv[i] <= w_data;
      end
      if (w_addr == BIAS_ADR) bias <= w_data;
    end
  end

  // Datapath: latch pixels, accumulate taps, add bias, capture result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      k     <= '0;
      px    <= '0;
      out_v <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            acc <= '0;
            k   <= '0;
            px  <= in_px;
          end
        end
        S_ACC: begin
          acc <= acc_add_c;
          k   <= k + 4'd1;
        end
        S_BIAS: begin
          acc   <= acc_bias_c;
          out_v <= res_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_var_mac_sched.sv
// Testbench for var_mac_sched: directed steps with a scoreboard queue of
// expected results built from a reference model of the coefficient file.
module tb_var_mac_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_we;
  logic [3:0]  w_addr;
  logic [19:0] w_data;
  logic        w_err;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_px;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_v;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int mw [9];
  int mb;
  logic [19:0] sb_q [$];

  var_mac_sched dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .w_err(w_err), .in_valid(in_valid), .in_ready(in_ready), .in_px(in_px),
    .out_valid(out_valid), .out_ready(out_ready), .out_v(out_v), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] model(input logic [8:0] p);
    int s;
    s = mb;
    for (int i = 0; i < 9; i++) if (p[i]) s += mw[i];
`ifdef VAR_MAC_SAT_EN
    if (s > 524287)  s = 524287;
    if (s < -524288) s = -524288;
`endif
    return 20'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [19:0] d);
    if (a == 4'd9) mb = int'($signed(d));
    else if (a < 4'd9) mw[a] = int'($signed(d));
  endtask

  task automatic do_write(input logic [3:0] a, input logic [19:0] d, input logic exp_err);
    w_we = 1'b1; w_addr = a; w_data = d;
    step();
    w_we = 1'b0;
    if (!exp_err) model_write(a, d);
    chk("w_err_pulse", 32'(w_err), 32'(exp_err));
    step();
    chk("w_err_clear", 32'(w_err), 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic accept(input logic [8:0] p);
    wait_ready();
    in_valid = 1'b1; in_px = p;
    sb_q.push_back(model(p));
    t_acc = cyc;
    step();
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic finish_patch(input int hold);
    int n;
    logic [19:0] held;
    logic [19:0] exp;
    out_ready = (hold == 0);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("latency", 32'(cyc - t_acc), 32'd11);
    if (hold > 0) begin
      held = out_v;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; in_px = 9'h1FF;
        step();
        chk("hold_out_v", 32'(out_v), 32'(held));
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      exp = '0;
    end else begin
      exp = sb_q.pop_front();
    end
    chk("out_v", 32'(out_v), 32'(exp));
    step();
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [19:0] d;
    rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_px = '0; out_ready = 1'b0;
    for (int i = 0; i < 9; i++) mw[i] = 0;
    mb = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_w_err", 32'(w_err), 32'd0);
    chk("rst_out_v", 32'(out_v), 32'd0);

    // Ramp weights, negative bias
    for (int i = 0; i < 9; i++) do_write(4'(i), 20'(i + 1), 1'b0);
    do_write(4'd9, 20'(-5), 1'b0);
    accept(9'h1FF);
    chk("model_ramp_all", 32'(sb_q[0]), 32'(20'd40));
    finish_patch(0);
    accept(9'h000);
    finish_patch(0);
    accept(9'h101);
    finish_patch(0);

    // Large coefficients: saturate or wrap
    for (int i = 0; i < 10; i++) do_write(4'(i), 20'd524287, 1'b0);
    accept(9'h1FF);
    finish_patch(0);

    // Backpressure in DONE with ignored offers
    accept(9'h0F0);
    finish_patch(5);

    // Rejected writes: during ACC and to an unmapped address
    for (int i = 0; i < 9; i++) do_write(4'(i), 20'(i + 1), 1'b0);
    do_write(4'd9, 20'(-5), 1'b0);
    accept(9'h1FF);
    do_write(4'd3, 20'd100, 1'b1);
    finish_patch(0);
    do_write(4'd12, 20'd77, 1'b1);
    accept(9'h008);
    finish_patch(0);

    // Write and acceptance in the same idle cycle
    wait_ready();
    d = 20'd1000;
    w_we = 1'b1; w_addr = 4'd0; w_data = d;
    in_valid = 1'b1; in_px = 9'h001;
    model_write(4'd0, d);
    sb_q.push_back(model(9'h001));
    t_acc = cyc;
    step();
    w_we = 1'b0; in_valid = 1'b0;
    chk("same_cycle_w_err", 32'(w_err), 32'd0);
    finish_patch(0);

    // Reset in ACC at k = 4 aborts the patch and clears coefficients
    accept(9'h1FF);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb_q.pop_back());
    for (int i = 0; i < 9; i++) mw[i] = 0;
    mb = 0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_v", 32'(out_v), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_no_out_valid", 32'(out_valid), 32'd0);
    end
    accept(9'h1FF);
    finish_patch(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
